// File: rtl/pipe_stage_skid_pkg.sv
// Shared constants and the occupancy state type for the skid pipeline stage.
// Included first; imported by the stage top.
package pipe_pkg;

  localparam int PC_W  = 32;
  localparam int EXC_W = 5;

  localparam logic [PC_W-1:0] HANDLER_PC_DEFAULT = 32'h0000_4180;

  // MIPS-style cause codes carried on the exception side-band.
  localparam logic [EXC_W-1:0] EXC_INT  = 5'd0;
  localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
  localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;
  localparam logic [EXC_W-1:0] EXC_SYS  = 5'd8;
  localparam logic [EXC_W-1:0] EXC_BP   = 5'd9;
  localparam logic [EXC_W-1:0] EXC_RI   = 5'd10;
  localparam logic [EXC_W-1:0] EXC_OV   = 5'd12;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } occ_e;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle between two CPU stages: upstream entry in, downstream entry out.
// slave = the pipeline stage, master = the surrounding logic.
interface pipe_stage_skid_if #(
  parameter int PAYLOAD_W = 160,
  parameter int PC_W      = pipe_pkg::PC_W,
  parameter int EXC_W     = pipe_pkg::EXC_W
);
  logic                 in_valid;
  logic                 in_ready;
  logic [PC_W-1:0]      in_pc;
  logic [PAYLOAD_W-1:0] in_payload;
  logic [EXC_W-1:0]     in_exc_code;
  logic                 in_bd;
  logic                 in_exc_ovdm;

  logic                 out_valid;
  logic                 out_ready;
  logic [PC_W-1:0]      out_pc;
  logic [PAYLOAD_W-1:0] out_payload;
  logic [EXC_W-1:0]     out_exc_code;
  logic                 out_bd;
  logic                 out_exc_ovdm;

  modport slave (
    input  in_valid, in_pc, in_payload, in_exc_code, in_bd, in_exc_ovdm, out_ready,
    output in_ready, out_valid, out_pc, out_payload, out_exc_code, out_bd, out_exc_ovdm
  );

  modport master (
    output in_valid, in_pc, in_payload, in_exc_code, in_bd, in_exc_ovdm, out_ready,
    input  in_ready, out_valid, out_pc, out_payload, out_exc_code, out_bd, out_exc_ovdm
  );
endinterface

// File: rtl/pipe_stage_skid_slot.sv
// pipe_slot: one stored pipeline entry (pc, payload, exception side-band).
// clear zeroes the entry and stamps CLEAR_PC; load captures the inputs.
module pipe_slot #(
  parameter int              PAYLOAD_W = 160,
  parameter int              PC_W      = 32,
  parameter int              EXC_W     = 5,
  parameter logic [PC_W-1:0] CLEAR_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic                 clear_i,
  input  logic [PC_W-1:0]      pc_i,
  input  logic [PAYLOAD_W-1:0] payload_i,
  input  logic [EXC_W-1:0]     exc_code_i,
  input  logic                 bd_i,
  input  logic                 ovdm_i,
  output logic [PC_W-1:0]      pc_o,
  output logic [PAYLOAD_W-1:0] payload_o,
  output logic [EXC_W-1:0]     exc_code_o,
  output logic                 bd_o,
  output logic                 ovdm_o
);

  logic [PC_W-1:0]      pc_q;
  logic [PAYLOAD_W-1:0] payload_q;
  logic [EXC_W-1:0]     exc_code_q;
  logic                 bd_q;
  logic                 ovdm_q;

  // NOTE: clear is tested before load so a flush wins over a same-cycle capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= '0;
      payload_q  <= '0;
      exc_code_q <= '0;
      bd_q       <= 1'b0;
      ovdm_q     <= 1'b0;
    end else if (clear_i) begin
      pc_q       <= CLEAR_PC;
      payload_q  <= '0;
      exc_code_q <= '0;
      bd_q       <= 1'b0;
      ovdm_q     <= 1'b0;
    end else if (load_i) begin
      pc_q       <= pc_i;
      payload_q  <= payload_i;
      exc_code_q <= exc_code_i;
      bd_q       <= bd_i;
      ovdm_q     <= ovdm_i;
    end
  end

  assign pc_o       = pc_q;
  assign payload_o  = payload_q;
  assign exc_code_o = exc_code_q;
  assign bd_o       = bd_q;
  assign ovdm_o     = ovdm_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake and flush-to-handler bubble.
// PIPE_SKID_BUF_EN adds a second (skid) slot and a registered in_ready.
module pipe_stage_skid #(
  parameter int              PAYLOAD_W  = 160,
  parameter int              PC_W       = pipe_pkg::PC_W,
  parameter int              EXC_W      = pipe_pkg::EXC_W,
  parameter logic [PC_W-1:0] HANDLER_PC = pipe_pkg::HANDLER_PC_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  pipe_stage_skid_if.slave bus
);
  import pipe_pkg::*;

  occ_e state_q, state_d;
  logic in_ready, out_valid, in_xfer, out_xfer;
  logic main_load, main_from_skid;

  logic [PC_W-1:0]      main_pc_d;
  logic [PAYLOAD_W-1:0] main_payload_d;
  logic [EXC_W-1:0]     main_exc_d;
  logic                 main_bd_d, main_ovdm_d;

  assign out_valid = (state_q != EMPTY);
  assign in_xfer   = bus.in_valid && in_ready;
  assign out_xfer  = out_valid && bus.out_ready;

`ifdef PIPE_SKID_BUF_EN
  logic                 skid_load;
  logic [PC_W-1:0]      skid_pc;
  logic [PAYLOAD_W-1:0] skid_payload;
  logic [EXC_W-1:0]     skid_exc;
  logic                 skid_bd, skid_ovdm;

  // NOTE: in_ready depends only on registered state (and reset), never on out_ready.
  assign in_ready = reset && (state_q != SKID);

  pipe_slot #(.PAYLOAD_W(PAYLOAD_W), .PC_W(PC_W), .EXC_W(EXC_W)) u_skid (
    .clk(clk), .rst_n(reset), .load_i(skid_load), .clear_i(flush),
    .pc_i(bus.in_pc), .payload_i(bus.in_payload), .exc_code_i(bus.in_exc_code),
    .bd_i(bus.in_bd), .ovdm_i(bus.in_exc_ovdm),
    .pc_o(skid_pc), .payload_o(skid_payload), .exc_code_o(skid_exc),
    .bd_o(skid_bd), .ovdm_o(skid_ovdm)
  );

  // MAIN refills from SKID when draining, otherwise from upstream.
  assign main_pc_d      = main_from_skid ? skid_pc      : bus.in_pc;
  assign main_payload_d = main_from_skid ? skid_payload : bus.in_payload;
  assign main_exc_d     = main_from_skid ? skid_exc     : bus.in_exc_code;
  assign main_bd_d      = main_from_skid ? skid_bd      : bus.in_bd;
  assign main_ovdm_d    = main_from_skid ? skid_ovdm    : bus.in_exc_ovdm;
`else
  assign in_ready       = reset && (!out_valid || bus.out_ready);
  assign main_pc_d      = bus.in_pc;
  assign main_payload_d = bus.in_payload;
  assign main_exc_d     = bus.in_exc_code;
  assign main_bd_d      = bus.in_bd;
  assign main_ovdm_d    = bus.in_exc_ovdm;
`endif

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
`ifdef PIPE_SKID_BUF_EN
    skid_load      = 1'b0;
`endif
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            main_load = 1'b1;
            state_d   = FULL;
          end
        end
        FULL: begin
`ifdef PIPE_SKID_BUF_EN
          if (in_xfer && !out_xfer) begin
            skid_load = 1'b1;
            state_d   = SKID;
          end else
`endif
          if (in_xfer) begin
            main_load = 1'b1;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
`ifdef PIPE_SKID_BUF_EN
        SKID: begin
          if (out_xfer) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            state_d        = FULL;
          end
        end
`endif
        default: state_d = EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignment only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  pipe_slot #(
    .PAYLOAD_W(PAYLOAD_W), .PC_W(PC_W), .EXC_W(EXC_W), .CLEAR_PC(HANDLER_PC)
  ) u_main (
    .clk(clk), .rst_n(reset), .load_i(main_load), .clear_i(flush),
    .pc_i(main_pc_d), .payload_i(main_payload_d), .exc_code_i(main_exc_d),
    .bd_i(main_bd_d), .ovdm_i(main_ovdm_d),
    .pc_o(bus.out_pc), .payload_o(bus.out_payload), .exc_code_o(bus.out_exc_code),
    .bd_o(bus.out_bd), .ovdm_o(bus.out_exc_ovdm)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid; works with PIPE_SKID_BUF_EN defined or not.
// Driver pushes accepted entries, a negedge monitor pops and compares on each output transfer.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  typedef struct packed {
    logic [31:0]  pc;
    logic [159:0] payload;
    logic [4:0]   exc;
    logic         bd;
    logic         ovdm;
  } entry_t;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  int   checks = 0;
  int   errors = 0;
  int   n_out  = 0;
  entry_t sb[$];

  pipe_stage_skid_if #(.PAYLOAD_W(160), .PC_W(32), .EXC_W(5)) bus ();

  pipe_stage_skid #(
    .PAYLOAD_W(160), .PC_W(32), .EXC_W(5), .HANDLER_PC(32'h0000_4180)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic entry_t mk(input logic [31:0] pc);
    entry_t e;
    e.pc      = pc;
    e.payload = {pc, ~pc, pc ^ 32'h5a5a_5a5a, ~pc, pc};
    e.exc     = pc[6:2];
    e.bd      = pc[2];
    e.ovdm    = pc[3];
    return e;
  endfunction

  task automatic drive(input logic v, input entry_t e);
    bus.in_valid    = v;
    bus.in_pc       = e.pc;
    bus.in_payload  = e.payload;
    bus.in_exc_code = e.exc;
    bus.in_bd       = e.bd;
    bus.in_exc_ovdm = e.ovdm;
  endtask

  // One clock: record acceptance at negedge, then move to just after the posedge.
  task automatic step(output logic acc);
    logic   fl;
    entry_t e;
    @(negedge clk);
    fl  = flush;
    acc = bus.in_valid && bus.in_ready && !fl;
    if (acc) begin
      e.pc = bus.in_pc; e.payload = bus.in_payload; e.exc = bus.in_exc_code;
      e.bd = bus.in_bd; e.ovdm = bus.in_exc_ovdm;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (fl) sb.delete();
  endtask

  task automatic tick();
    logic a;
    step(a);
  endtask

  initial begin
    entry_t got, exp;
    forever begin
      @(negedge clk);
      if (reset && bus.out_valid && bus.out_ready) begin
        n_out++;
        got = {bus.out_pc, bus.out_payload, bus.out_exc_code, bus.out_bd, bus.out_exc_ovdm};
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected: got pc %0h expected no entry", got.pc);
        end else begin
          exp = sb.pop_front();
          check("out_entry", 256'(got), 256'(exp));
        end
      end
    end
  end

  initial begin
    entry_t bp[3];
    logic   acc;
    int     idx, n0;
    logic   skid_on;
`ifdef PIPE_SKID_BUF_EN
    skid_on = 1'b1;
`else
    skid_on = 1'b0;
`endif
    reset = 1'b0; flush = 1'b0; bus.out_ready = 1'b0;
    drive(1'b0, mk(32'h0));

    // Reset state and release.
    #1;
    check("rst_out_valid", 256'(bus.out_valid), 256'(0));
    check("rst_out_pc", 256'(bus.out_pc), 256'(0));
    check("rst_in_ready", 256'(bus.in_ready), 256'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("rel_in_ready", 256'(bus.in_ready), 256'(1));
    check("rel_out_valid", 256'(bus.out_valid), 256'(0));

    // Streaming: one-cycle latency, no gaps.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, mk(32'h3000 + 32'(i * 4)));
      tick();
      check("stream_valid", 256'(bus.out_valid), 256'(1));
      check("stream_pc", 256'(bus.out_pc), 256'(32'h3000 + 32'(i * 4)));
    end
    drive(1'b0, mk(32'h0));
    tick();
    tick();
    check("stream_drained", 256'(sb.size()), 256'(0));
    check("stream_count", 256'(n_out), 256'(8));

    // Side-band pass-through.
    drive(1'b1, '{pc: 32'h3020, payload: '1, exc: EXC_ADEL, bd: 1'b1, ovdm: 1'b1});
    tick();
    drive(1'b0, mk(32'h0));
    check("sb_pc", 256'(bus.out_pc), 256'(32'h3020));
    check("sb_payload", 256'(bus.out_payload), 256'({160{1'b1}}));
    check("sb_exc", 256'(bus.out_exc_code), 256'(5'd4));
    check("sb_bd", 256'(bus.out_bd), 256'(1));
    check("sb_ovdm", 256'(bus.out_exc_ovdm), 256'(1));
    tick();

    // Backpressure: hold out_ready low for four cycles.
    bp[0] = mk(32'h3000); bp[1] = mk(32'h3004); bp[2] = mk(32'h3008);
    idx = 0;
    n0  = n_out;
    for (int c = 0; c < 12; c++) begin
      bus.out_ready = (c >= 4);
      if (idx < 3) drive(1'b1, bp[idx]);
      else         drive(1'b0, mk(32'h0));
      if (c == 2) begin
        bus.out_ready = 1'b1;
        #1 check("bp_ready_comb_hi", 256'(bus.in_ready), 256'(!skid_on));
        bus.out_ready = 1'b0;
        #1 check("bp_ready_comb_lo", 256'(bus.in_ready), 256'(0));
      end
      step(acc);
      if (acc) idx++;
      if (c == 0) check("bp_ready_after1", 256'(bus.in_ready), 256'(skid_on));
      if (c == 1) begin
        check("bp_ready_after2", 256'(bus.in_ready), 256'(0));
        check("bp_accepted", 256'(idx), skid_on ? 256'(2) : 256'(1));
      end
      if (c >= 1 && c <= 3) begin
        check("bp_hold_valid", 256'(bus.out_valid), 256'(1));
        check("bp_hold_pc", 256'(bus.out_pc), 256'(32'h3000));
      end
    end
    check("bp_all_sent", 256'(idx), 256'(3));
    check("bp_drained", 256'(sb.size()), 256'(0));
    check("bp_count", 256'(n_out - n0), 256'(3));

    // Reset mid-stream.
    bus.out_ready = 1'b0;
    drive(1'b1, mk(32'h3000));
    tick();
    drive(1'b0, mk(32'h0));
    check("mid_full_pc", 256'(bus.out_pc), 256'(32'h3000));
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 256'(bus.out_valid), 256'(0));
    check("mid_rst_pc", 256'(bus.out_pc), 256'(0));
    check("mid_rst_ready", 256'(bus.in_ready), 256'(0));
    sb.delete();
    @(posedge clk);
    #1 reset = 1'b1;
    #1 check("mid_rel_ready", 256'(bus.in_ready), 256'(1));

    // Flush while holding data, with a live input, held for two cycles.
    bus.out_ready = 1'b0;
    drive(1'b1, mk(32'h3000));
    tick();
    drive(1'b1, mk(32'h3004));
    tick();
    flush = 1'b1;
    drive(1'b1, '{pc: 32'h3010, payload: '1, exc: EXC_OV, bd: 1'b1, ovdm: 1'b1});
    tick();
    check("fl_valid", 256'(bus.out_valid), 256'(0));
    check("fl_pc", 256'(bus.out_pc), 256'(32'h4180));
    check("fl_exc", 256'(bus.out_exc_code), 256'(0));
    check("fl_payload", 256'(bus.out_payload), 256'(0));
    check("fl_bd_ovdm", 256'({bus.out_bd, bus.out_exc_ovdm}), 256'(0));
    check("fl_ready_during", 256'(bus.in_ready), 256'(1));
    tick();
    check("fl2_valid", 256'(bus.out_valid), 256'(0));
    check("fl2_pc", 256'(bus.out_pc), 256'(32'h4180));
    flush = 1'b0;
    drive(1'b0, mk(32'h0));
    bus.out_ready = 1'b1;
    n0 = n_out;
    repeat (3) tick();
    check("fl_no_ghost", 256'(n_out - n0), 256'(0));
    check("fl_bubble_pc", 256'(bus.out_pc), 256'(32'h4180));
    drive(1'b1, mk(32'h3014));
    tick();
    drive(1'b0, mk(32'h0));
    check("fl_recover_pc", 256'(bus.out_pc), 256'(32'h3014));
    tick();
    tick();
    check("fl_drained", 256'(sb.size()), 256'(0));
    check("fl_count", 256'(n_out - n0), 256'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish before 20000");
    $fatal(1, "timeout");
  end

endmodule
